// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-unit operation codes, sequencer state and flag bundle.
package alu_pkg;

   // Logic-unit operation codes. Bit {b,a} of the code is the output for operand bits b,a.
   localparam logic [3:0] ALU_OP_ZERO   = 4'h0;
   localparam logic [3:0] ALU_OP_NOR    = 4'h1;
   localparam logic [3:0] ALU_OP_ANB    = 4'h2;
   localparam logic [3:0] ALU_OP_NB     = 4'h3;
   localparam logic [3:0] ALU_OP_NAB    = 4'h4;
   localparam logic [3:0] ALU_OP_NA     = 4'h5;
   localparam logic [3:0] ALU_OP_XOR    = 4'h6;
   localparam logic [3:0] ALU_OP_NAND   = 4'h7;
   localparam logic [3:0] ALU_OP_AND    = 4'h8;
   localparam logic [3:0] ALU_OP_XNOR   = 4'h9;
   localparam logic [3:0] ALU_OP_A      = 4'hA;
   localparam logic [3:0] ALU_OP_ANB_OR = 4'hB;
   localparam logic [3:0] ALU_OP_B      = 4'hC;
   localparam logic [3:0] ALU_OP_NA_OR  = 4'hD;
   localparam logic [3:0] ALU_OP_OR     = 4'hE;
   localparam logic [3:0] ALU_OP_ONES   = 4'hF;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StStrobe,
      StCapture,
      StResp
   } alu_seq_state_t;

   typedef struct packed {
      logic zero;
      logic neg;
      logic ones;
      logic parity;
   } alu_flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational result flags: zero, sign bit, all-ones and odd parity.
module alu_flag_gen #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] result_i,
   output logic             zero_o,
   output logic             neg_o,
   output logic             ones_o,
   output logic             parity_o
);

   // Pure reductions of the result; no carry or arithmetic involved.
   always_comb begin
      zero_o   = ~|result_i;
      neg_o    = result_i[WIDTH-1];
      ones_o   = &result_i;
      parity_o = ^result_i;
   end

endmodule

// File: rtl/alu_logic_sequencer.sv
// Request/response sequencer around the logic unit: holds operands, strobes alu_clk once
// per request, captures the unit's registered output and returns it with flags.
module alu_logic_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned SETUP_CYCLES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [WIDTH-1:0] req_lhs,
   input  logic [WIDTH-1:0] req_rhs,
   output logic             alu_clk,
   output logic [3:0]       operation,
   output logic [WIDTH-1:0] lhs_out,
   output logic [WIDTH-1:0] rhs_out,
   input  logic [WIDTH-1:0] logic_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_neg,
   output logic             rsp_ones,
   output logic             rsp_parity
);

   if (SETUP_CYCLES == 0 || SETUP_CYCLES > 15) begin : g_bad_setup
      $error("alu_logic_sequencer: SETUP_CYCLES must be in 1..15");
   end

   localparam logic [3:0] CntLoad = 4'(SETUP_CYCLES - 1);

   alu_seq_state_t   state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             alu_clk_q, alu_clk_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] lhs_q, lhs_d;
   logic [WIDTH-1:0] rhs_q, rhs_d;
   logic [WIDTH-1:0] res_q, res_d;
   alu_flags_t       flags_q, flags_d;
   logic             rsp_valid_q, rsp_valid_d;
   alu_flags_t       unit_flags;

   // Flags are derived from the value being captured so they register alongside it.
   alu_flag_gen #(
      .WIDTH (WIDTH)
   ) u_flag_gen (
      .result_i (logic_result),
      .zero_o   (unit_flags.zero),
      .neg_o    (unit_flags.neg),
      .ones_o   (unit_flags.ones),
      .parity_o (unit_flags.parity)
   );

   // Next-state logic: accept, setup countdown, single strobe, capture, response hold.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_clk_d   = 1'b0;
      op_d        = op_q;
      lhs_d       = lhs_q;
      rhs_d       = rhs_q;
      res_d       = res_q;
      flags_d     = flags_q;
      rsp_valid_d = rsp_valid_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               op_d    = req_op;
               lhs_d   = req_lhs;
               rhs_d   = req_rhs;
               cnt_d   = CntLoad;
               state_d = StSetup;
            end
         end
         StSetup: begin
            if (cnt_q == '0) begin
               alu_clk_d = 1'b1;
               state_d   = StStrobe;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StStrobe: begin
            state_d = StCapture;
         end
         StCapture: begin
            // Only reached right after a strobe, so the unit output is fresh here.
            res_d       = logic_result;
            flags_d     = unit_flags;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         alu_clk_q   <= 1'b0;
         op_q        <= '0;
         lhs_q       <= '0;
         rhs_q       <= '0;
         res_q       <= '0;
         flags_q     <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alu_clk_q   <= alu_clk_d;
         op_q        <= op_d;
         lhs_q       <= lhs_d;
         rhs_q       <= rhs_d;
         res_q       <= res_d;
         flags_q     <= flags_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Output mapping; alu_clk comes straight from a flop so it is glitch-free.
   always_comb begin
      req_ready  = (state_q == StIdle);
      alu_clk    = alu_clk_q;
      operation  = op_q;
      lhs_out    = lhs_q;
      rhs_out    = rhs_q;
      rsp_valid  = rsp_valid_q;
      rsp_result = res_q;
      rsp_zero   = flags_q.zero;
      rsp_neg    = flags_q.neg;
      rsp_ones   = flags_q.ones;
      rsp_parity = flags_q.parity;
   end

endmodule

// File: tb/tb_alu_logic_sequencer.sv
// Bench for alu_logic_sequencer with a behavioural logic unit clocked by alu_clk.
module tb_alu_logic_sequencer;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;

   // Default-configuration DUT
   logic       req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0;
   logic [3:0] req_op = '0, operation;
   logic [7:0] req_lhs = '0, req_rhs = '0, lhs_out, rhs_out, logic_result, rsp_result;
   logic       alu_clk, rsp_zero, rsp_neg, rsp_ones, rsp_parity;

   // SETUP_CYCLES=3 DUT
   logic       req_valid3 = 1'b0, req_ready3, rsp_valid3, rsp_ready3 = 1'b0;
   logic [3:0] req_op3 = '0, operation3;
   logic [7:0] req_lhs3 = '0, req_rhs3 = '0, lhs_out3, rhs_out3, logic_result3, rsp_result3;
   logic       alu_clk3, rsp_zero3, rsp_neg3, rsp_ones3, rsp_parity3;

   int n_cmp = 0;
   int n_err = 0;
   int pulses = 0;
   int pulses3 = 0;

   always #5 clk = ~clk;

   alu_logic_sequencer #(.WIDTH(8), .SETUP_CYCLES(1)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_lhs(req_lhs), .req_rhs(req_rhs), .alu_clk(alu_clk),
      .operation(operation), .lhs_out(lhs_out), .rhs_out(rhs_out),
      .logic_result(logic_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
      .rsp_ones(rsp_ones), .rsp_parity(rsp_parity)
   );

   alu_logic_sequencer #(.WIDTH(8), .SETUP_CYCLES(3)) u_dut3 (
      .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_op(req_op3), .req_lhs(req_lhs3), .req_rhs(req_rhs3), .alu_clk(alu_clk3),
      .operation(operation3), .lhs_out(lhs_out3), .rhs_out(rhs_out3),
      .logic_result(logic_result3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
      .rsp_result(rsp_result3), .rsp_zero(rsp_zero3), .rsp_neg(rsp_neg3),
      .rsp_ones(rsp_ones3), .rsp_parity(rsp_parity3)
   );

   // Stand-in for the logic unit: registered on alu_clk, no reset.
   function automatic logic [7:0] unit_fn(logic [3:0] op, logic [7:0] a, logic [7:0] b);
      case (op)
         ALU_OP_ZERO:   return 8'h00;
         ALU_OP_NOR:    return ~(a | b);
         ALU_OP_ANB:    return a & ~b;
         ALU_OP_NB:     return ~b;
         ALU_OP_NAB:    return ~a & b;
         ALU_OP_NA:     return ~a;
         ALU_OP_XOR:    return a ^ b;
         ALU_OP_NAND:   return ~(a & b);
         ALU_OP_AND:    return a & b;
         ALU_OP_XNOR:   return ~(a ^ b);
         ALU_OP_A:      return a;
         ALU_OP_ANB_OR: return a | ~b;
         ALU_OP_B:      return b;
         ALU_OP_NA_OR:  return ~a | b;
         ALU_OP_OR:     return a | b;
         default:       return 8'hFF;
      endcase
   endfunction

   always @(posedge alu_clk) begin
      logic_result <= unit_fn(operation, lhs_out, rhs_out);
      pulses <= pulses + 1;
   end

   always @(posedge alu_clk3) begin
      logic_result3 <= unit_fn(operation3, lhs_out3, rhs_out3);
      pulses3 <= pulses3 + 1;
   end

   // Reference: each op code is a 2-input truth table indexed by {b,a} per bit.
   function automatic logic [11:0] exp_pack(logic [3:0] op, logic [7:0] a, logic [7:0] b);
      logic [7:0] r;
      int pop;
      pop = 0;
      for (int i = 0; i < 8; i++) begin
         r[i] = op[{b[i], a[i]}];
         pop += int'(r[i]);
      end
      return {r, r == 8'h00, r >= 8'h80, r == 8'hFF, (pop % 2) == 1};
   endfunction

   function automatic logic [11:0] obs();
      return {rsp_result, rsp_zero, rsp_neg, rsp_ones, rsp_parity};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one edge; req_* are scrambled afterwards to expose sampling bugs.
   task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      n_cmp++;
      if (req_ready !== 1'b1) begin
         $display("FAIL send_ready: req_ready=%b required 1", req_ready);
         n_err++;
      end
      req_op = op; req_lhs = a; req_rhs = b; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      req_op = 4'($urandom); req_lhs = 8'($urandom); req_rhs = 8'($urandom);
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      n_cmp++;
      if (rsp_valid !== 1'b1) begin
         $display("FAIL rsp_timeout: rsp_valid=%b after %0d edges required 1", rsp_valid, lat);
         n_err++;
      end
   endtask

   task automatic release_rsp();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      n_cmp++;
      if ({req_ready, alu_clk, rsp_valid} !== 3'b100) begin
         $display("FAIL reset_ctrl: ready/alu_clk/valid=%b required 100",
                  {req_ready, alu_clk, rsp_valid});
         n_err++;
      end
      n_cmp++;
      if ({operation, lhs_out, rhs_out} !== 20'h0) begin
         $display("FAIL reset_operands: %h required 00000", {operation, lhs_out, rhs_out});
         n_err++;
      end
      n_cmp++;
      if (obs() !== 12'h000) begin
         $display("FAIL reset_rsp: result/flags=%h required 000", obs());
         n_err++;
      end
      n_cmp++;
      if ({req_ready3, alu_clk3, rsp_valid3} !== 3'b100) begin
         $display("FAIL reset_ctrl3: %b required 100", {req_ready3, alu_clk3, rsp_valid3});
         n_err++;
      end
   endtask

   task automatic test_directed();
      int lat;
      logic [7:0] a, b;
      send(4'h8, 8'hF0, 8'h3C);
      wait_rsp(lat);
      n_cmp++;
      if (lat !== 3) begin
         $display("FAIL and_latency: %0d edges required 3", lat);
         n_err++;
      end
      n_cmp++;
      if (obs() !== {8'h30, 4'b0000}) begin
         $display("FAIL and_rsp: %h required 300", obs());
         n_err++;
      end
      release_rsp();
      send(4'h9, 8'hAA, 8'h55);
      wait_rsp(lat);
      n_cmp++;
      if (obs() !== {8'h00, 4'b1000}) begin
         $display("FAIL xnor_rsp: %h required 008", obs());
         n_err++;
      end
      release_rsp();
      a = 8'($urandom); b = 8'($urandom);
      send(4'hF, a, b);
      wait_rsp(lat);
      n_cmp++;
      if (obs() !== {8'hFF, 4'b0110}) begin
         $display("FAIL ones_rsp: %h required FF6", obs());
         n_err++;
      end
      release_rsp();
   endtask

   task automatic test_setup3();
      logic [7:0] hist;
      int first_valid;
      int p0;
      p0 = pulses3;
      hist = '0;
      first_valid = 0;
      n_cmp++;
      if (req_ready3 !== 1'b1) begin
         $display("FAIL setup3_ready: %b required 1", req_ready3);
         n_err++;
      end
      req_op3 = 4'hE; req_lhs3 = 8'h01; req_rhs3 = 8'h02; req_valid3 = 1'b1;
      tick();
      req_valid3 = 1'b0;
      for (int t = 1; t <= 8; t++) begin
         tick();
         hist[t-1] = alu_clk3;
         if (rsp_valid3 === 1'b1 && first_valid == 0) first_valid = t;
      end
      n_cmp++;
      if (hist !== 8'b0000_0100) begin
         $display("FAIL setup3_strobe: alu_clk history %b required 00000100", hist);
         n_err++;
      end
      n_cmp++;
      if (first_valid !== 5) begin
         $display("FAIL setup3_latency: rsp_valid at edge %0d required 5", first_valid);
         n_err++;
      end
      n_cmp++;
      if ({rsp_result3, rsp_zero3, rsp_neg3, rsp_ones3, rsp_parity3} !== {8'h03, 4'b0000}) begin
         $display("FAIL setup3_rsp: %h required 030",
                  {rsp_result3, rsp_zero3, rsp_neg3, rsp_ones3, rsp_parity3});
         n_err++;
      end
      n_cmp++;
      if (pulses3 - p0 !== 1) begin
         $display("FAIL setup3_pulses: %0d required 1", pulses3 - p0);
         n_err++;
      end
      rsp_ready3 = 1'b1;
      tick();
      rsp_ready3 = 1'b0;
      n_cmp++;
      if ({rsp_valid3, req_ready3} !== 2'b01) begin
         $display("FAIL setup3_release: valid/ready=%b required 01", {rsp_valid3, req_ready3});
         n_err++;
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] op, nop;
      logic [7:0] a, b, na, nb;
      int lat, p0;
      op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
      send(op, a, b);
      wait_rsp(lat);
      p0 = pulses;
      nop = ~op; na = ~a; nb = 8'($urandom);
      req_op = nop; req_lhs = na; req_rhs = nb; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({rsp_valid, req_ready, obs(), operation, lhs_out, rhs_out} !==
             {2'b10, exp_pack(op, a, b), op, a, b}) begin
            $display("FAIL hold_%0d: valid/ready/rsp/ops=%h required %h", i,
                     {rsp_valid, req_ready, obs(), operation, lhs_out, rhs_out},
                     {2'b10, exp_pack(op, a, b), op, a, b});
            n_err++;
         end
         tick();
      end
      n_cmp++;
      if (pulses !== p0) begin
         $display("FAIL hold_pulses: %0d extra alu_clk pulses required 0", pulses - p0);
         n_err++;
      end
      release_rsp();
      n_cmp++;
      if ({rsp_valid, req_ready, operation} !== {2'b01, op}) begin
         $display("FAIL release_idle: valid/ready/op=%b required %b",
                  {rsp_valid, req_ready, operation}, {2'b01, op});
         n_err++;
      end
      tick();
      req_valid = 1'b0;
      n_cmp++;
      if ({req_ready, operation, lhs_out, rhs_out} !== {1'b0, nop, na, nb}) begin
         $display("FAIL next_accept: ready/ops=%h required %h",
                  {req_ready, operation, lhs_out, rhs_out}, {1'b0, nop, na, nb});
         n_err++;
      end
      wait_rsp(lat);
      n_cmp++;
      if (obs() !== exp_pack(nop, na, nb)) begin
         $display("FAIL next_rsp: %h required %h", obs(), exp_pack(nop, na, nb));
         n_err++;
      end
      release_rsp();
   endtask

   task automatic test_back_to_back();
      logic [11:0] exp_q[$];
      logic [19:0] cur;
      logic [3:0]  op;
      logic [7:0]  a, b;
      int sent, got, cyc, p0;
      bit busy;
      sent = 0; got = 0; cyc = 0; busy = 0; cur = '0;
      p0 = pulses;
      rsp_ready = 1'b1;
      while (got < 4 && cyc < 200) begin
         if (rsp_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0 || obs() !== exp_q[0]) begin
               $display("FAIL b2b_rsp_%0d: %h required %h", got, obs(),
                        exp_q.size() == 0 ? 12'hxxx : exp_q[0]);
               n_err++;
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            got++;
         end
         if (busy && req_ready !== 1'b1) begin
            n_cmp++;
            if ({operation, lhs_out, rhs_out} !== cur) begin
               $display("FAIL b2b_operands: %h required %h", {operation, lhs_out, rhs_out}, cur);
               n_err++;
            end
         end
         if (req_ready === 1'b1 && sent < 4) begin
            op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
            req_op = op; req_lhs = a; req_rhs = b; req_valid = 1'b1;
            exp_q.push_back(exp_pack(op, a, b));
            cur = {op, a, b};
            sent++;
            busy = 1;
         end else begin
            req_valid = 1'b0;
         end
         tick();
         cyc++;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      n_cmp++;
      if (got !== 4) begin
         $display("FAIL b2b_count: %0d responses required 4", got);
         n_err++;
      end
      n_cmp++;
      if (pulses - p0 !== 4) begin
         $display("FAIL b2b_pulses: %0d alu_clk pulses required 4", pulses - p0);
         n_err++;
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      bit saw;
      logic [7:0] b;
      send(4'($urandom), 8'($urandom), 8'($urandom));
      tick();
      n_cmp++;
      if (alu_clk !== 1'b1) begin
         $display("FAIL mid_strobe: alu_clk=%b required 1", alu_clk);
         n_err++;
      end
      reset = 1'b1;
      tick();
      n_cmp++;
      if ({alu_clk, rsp_valid, req_ready, operation} !== 7'b0010000) begin
         $display("FAIL mid_reset: alu_clk/valid/ready/op=%b required 0010000",
                  {alu_clk, rsp_valid, req_ready, operation});
         n_err++;
      end
      reset = 1'b0;
      saw = 0;
      repeat (6) begin
         tick();
         if (rsp_valid !== 1'b0) saw = 1;
      end
      n_cmp++;
      if (saw) begin
         $display("FAIL mid_dropped: response seen=1 required 0");
         n_err++;
      end
      b = 8'($urandom);
      send(4'h5, 8'h0F, b);
      wait_rsp(lat);
      n_cmp++;
      if (obs() !== {8'hF0, 4'b0100} || obs() !== exp_pack(4'h5, 8'h0F, b)) begin
         $display("FAIL mid_na: %h required F04", obs());
         n_err++;
      end
      release_rsp();
   endtask

   task automatic test_random();
      logic [3:0] op;
      logic [7:0] a, b;
      int lat, dly;
      for (int k = 0; k < 24; k++) begin
         op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
         send(op, a, b);
         wait_rsp(lat);
         n_cmp++;
         if (lat !== 3 || obs() !== exp_pack(op, a, b)) begin
            $display("FAIL rand_%0d: op=%h lat=%0d rsp=%h required lat=3 rsp=%h", k, op, lat,
                     obs(), exp_pack(op, a, b));
            n_err++;
         end
         dly = int'($urandom_range(0, 3));
         repeat (dly) tick();
         n_cmp++;
         if (rsp_valid !== 1'b1 || obs() !== exp_pack(op, a, b)) begin
            $display("FAIL rand_hold_%0d: valid=%b rsp=%h required 1 %h", k, rsp_valid, obs(),
                     exp_pack(op, a, b));
            n_err++;
         end
         release_rsp();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_setup3();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
